// File: rtl/dec_sweep_pkg.sv
// Shared definitions for the decode/sweep block: default select width and FSM state encodings.
package dec_sweep_pkg;

  localparam int DEFAULT_AW = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

endpackage

// File: rtl/dec_sweep_onehot.sv
// Combinational one-hot decoder: Y has bit I set when En is high, otherwise all-zero.
module dec_onehot #(
  parameter int AW = dec_sweep_pkg::DEFAULT_AW
) (
  input  logic [AW-1:0]     I,
  input  logic              En,
  output logic [2**AW-1:0]  Y
);

  always_comb begin
    Y = '0;
    if (En) Y[I] = 1'b1;
  end

endmodule

// File: rtl/dec_sweep.sv
// Registered one-hot decoder with a self-timed sweep mode that walks every output index once.
module dec_sweep
  import dec_sweep_pkg::*;
#(
  parameter int AW = DEFAULT_AW,
  parameter int N  = 2**AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          En,
  input  logic [AW-1:0] I,
  input  logic          Sweep,
  input  logic          Dir,
  output logic [N-1:0]  Y,
  output logic          Busy,
  output logic          Done,
  output state_t        dbg_state
);

  localparam logic [AW-1:0] IDX_MAX = {AW{1'b1}};

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic [N-1:0]  y_q, y_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [AW-1:0] dec_sel;
  logic          dec_en;
  logic [AW-1:0] last_idx;

  dec_onehot #(.AW(AW)) u_dec (
    .I  (dec_sel),
    .En (dec_en),
    .Y  (y_d)
  );

  assign last_idx = dir_q ? '0 : IDX_MAX;

  // The decoder always sees the index that will be registered this edge,
  // so in SWEEP it is fed the stepped counter rather than the current one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    dec_sel = I;
    dec_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Sweep) begin
          state_d = ST_SWEEP;
          dir_d   = Dir;
          cnt_d   = Dir ? IDX_MAX : '0;
          dec_sel = cnt_d;
          dec_en  = 1'b1;
          busy_d  = 1'b1;
        end else begin
          dec_sel = I;
          dec_en  = En;
        end
      end
      ST_SWEEP: begin
        if (cnt_q == last_idx) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = dir_q ? (cnt_q - AW'(1)) : (cnt_q + AW'(1));
          dec_sel = cnt_d;
          dec_en  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Y         = y_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dec_sweep.sv
// Directed bench for dec_sweep at AW=5 and AW=3 with hand-computed expected outputs.
module tb_dec_sweep;
  import dec_sweep_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, sweep, dir;
  logic [4:0]  sel;
  logic [31:0] y;
  logic        busy, done;
  state_t      st;

  logic        en8, sweep8, dir8;
  logic [2:0]  sel8;
  logic [7:0]  y8;
  logic        busy8, done8;
  state_t      st8;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  dec_sweep #(.AW(5)) dut (
    .clk(clk), .rst(rst), .En(en), .I(sel), .Sweep(sweep), .Dir(dir),
    .Y(y), .Busy(busy), .Done(done), .dbg_state(st)
  );

  dec_sweep #(.AW(3)) dut8 (
    .clk(clk), .rst(rst), .En(en8), .I(sel8), .Sweep(sweep8), .Dir(dir8),
    .Y(y8), .Busy(busy8), .Done(done8), .dbg_state(st8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ey, input logic eb, input logic ed);
    chk({tag, ".Y"}, y, ey);
    chk({tag, ".Busy"}, {31'b0, busy}, {31'b0, eb});
    chk({tag, ".Done"}, {31'b0, done}, {31'b0, ed});
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sel = '0; sweep = 1'b0; dir = 1'b0;
    en8 = 1'b0; sel8 = '0; sweep8 = 1'b0; dir8 = 1'b0;
    #3;
    chk_out("reset", 32'h0, 1'b0, 1'b0);
    #3 rst = 1'b0;
    step();
    chk_out("idle_disabled", 32'h0, 1'b0, 1'b0);

    // Single-decode walk
    en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      sel = i[4:0];
      step();
      chk($sformatf("walk%0d", i), y, 32'h1 << i);
    end
    en = 1'b0;
    step();
    chk_out("walk_off", 32'h0, 1'b0, 1'b0);

    // Up sweep
    sweep = 1'b1; dir = 1'b0;
    for (int k = 0; k < 32; k++) begin
      step();
      sweep = 1'b0;
      chk_out($sformatf("up%0d", k), 32'h1 << k, 1'b1, 1'b0);
    end
    step();
    chk_out("up_done", 32'h0, 1'b0, 1'b1);
    step();
    chk_out("up_after", 32'h0, 1'b0, 1'b0);

    // Down sweep with En/I held and a re-pulse at cycle 10
    en = 1'b1; sel = 5'd3; sweep = 1'b1; dir = 1'b1;
    for (int k = 0; k < 32; k++) begin
      step();
      sweep = (k == 9);
      dir   = (k == 9) ? 1'b0 : 1'b1;
      chk_out($sformatf("down%0d", k), 32'h8000_0000 >> k, 1'b1, 1'b0);
    end
    sweep = 1'b0;
    step();
    chk_out("down_done", 32'h0, 1'b0, 1'b1);
    step();
    chk_out("down_after_idle_decode", 32'h8, 1'b0, 1'b0);
    en = 1'b0; sel = '0;
    step();
    chk_out("down_quiet", 32'h0, 1'b0, 1'b0);

    // Reset during sweep cycle 7
    sweep = 1'b1; dir = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      sweep = 1'b0;
    end
    chk_out("pre_rst", 32'h40, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_out("mid_rst", 32'h0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_out($sformatf("post_rst%0d", k), 32'h0, 1'b0, 1'b0);
    end

    // Back-to-back sweeps: second requested in the Done cycle
    sweep = 1'b1; dir = 1'b0;
    for (int k = 0; k < 32; k++) begin
      step();
      sweep = 1'b0;
    end
    chk_out("b2b_last", 32'h8000_0000, 1'b1, 1'b0);
    step();
    chk_out("b2b_done", 32'h0, 1'b0, 1'b1);
    sweep = 1'b1; dir = 1'b1;
    for (int k = 0; k < 32; k++) begin
      step();
      sweep = 1'b0;
      chk_out($sformatf("b2b2_%0d", k), 32'h8000_0000 >> k, 1'b1, 1'b0);
    end
    step();
    chk_out("b2b2_done", 32'h0, 1'b0, 1'b1);

    // AW=3 instance
    chk("n8_idle.Y", {24'b0, y8}, 32'h0);
    sweep8 = 1'b1; dir8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      sweep8 = 1'b0;
      chk($sformatf("n8_up%0d.Y", k), {24'b0, y8}, 32'h1 << k);
      chk($sformatf("n8_up%0d.Busy", k), {31'b0, busy8}, 32'h1);
    end
    step();
    chk("n8_done.Y", {24'b0, y8}, 32'h0);
    chk("n8_done.Done", {31'b0, done8}, 32'h1);
    chk("n8_done.Busy", {31'b0, busy8}, 32'h0);
    en8 = 1'b1; sel8 = 3'd5;
    step();
    chk("n8_decode.Y", {24'b0, y8}, 32'h20);
    chk("n8_decode.Done", {31'b0, done8}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
